// File: rtl/tetris_cmd_scheduler.sv
// tetris_cmd_scheduler
// Sequences the tetris core: turns debounced button levels into one-shot
// move commands, generates gravity ticks whose period shrinks with level,
// and serialises both onto one command port. Tracks game phase.
//
// Ports:
//   clk, reset   : system clock, synchronous active-high reset
//   btn[3:0]     : debounced button levels, btn[i] -> move code i
//   cmd_ready    : core accepts cmd when high together with cmd_valid
//   line_clear   : one-cycle pulse per line cleared by the core
//   game_over    : level from the core, stack topped out
//   cmd_valid    : command offered to the core
//   cmd[2:0]     : 0..3 button move code, 4 gravity down
//   new_game     : one-cycle pulse, core must clear its board
//   level[3:0]   : current level, saturates at 15
//   overflow     : sticky, a press was dropped on a full queue
//   phase[1:0]   : 0 IDLE, 1 RUN, 2 OVER (also the FSM state)
//
// Handshake: a transfer happens on any rising edge where cmd_valid and
// cmd_ready are both high. While cmd_valid is high without cmd_ready, cmd
// is held stable. A new command may load in the same edge as a transfer,
// giving back-to-back issue. Reset drops any outstanding command.
module tetris_cmd_scheduler #(
  parameter int unsigned GRAVITY_PERIOD  = 50000000,
  parameter int unsigned GRAVITY_STEP    = 3000000,
  parameter int unsigned MIN_PERIOD      = 5000000,
  parameter int unsigned LINES_PER_LEVEL = 10,
  parameter int unsigned FIFO_DEPTH      = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] btn,
  input  logic       cmd_ready,
  input  logic       line_clear,
  input  logic       game_over,
  output logic       cmd_valid,
  output logic [2:0] cmd,
  output logic       new_game,
  output logic [3:0] level,
  output logic       overflow,
  output logic [1:0] phase
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);
  localparam logic [31:0] GP  = 32'(GRAVITY_PERIOD);
  localparam logic [31:0] MP  = 32'(MIN_PERIOD);
  localparam logic [31:0] LPL = 32'(LINES_PER_LEVEL);
  localparam logic [31:0] BASE_PERIOD = (GP < MP) ? MP : GP;

  localparam logic [1:0] PH_IDLE = 2'd0;
  localparam logic [1:0] PH_RUN  = 2'd1;
  localparam logic [1:0] PH_OVER = 2'd2;

  logic [3:0]    btn_q;
  logic [3:0]    press;
  logic          press_any;
  logic [1:0]    press_code;

  logic [1:0]    fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   fifo_cnt;
  logic          fifo_full;

  logic [31:0]   grav_cnt;
  logic [31:0]   cur_period;
  logic [31:0]   next_period;
  logic [31:0]   dec;
  logic          grav_pending;
  logic [31:0]   line_cnt;

  logic start, go_over, active, can_issue, issue_grav, issue_btn;
  logic push, drop, tick;

  // Rising-edge detect with fixed btn0 > btn1 > btn2 > btn3 priority.
  always_comb begin
    press      = btn & ~btn_q;
    press_any  = |press;
    press_code = 2'd3;
    if (press[0])      press_code = 2'd0;
    else if (press[1]) press_code = 2'd1;
    else if (press[2]) press_code = 2'd2;
  end

  // Period for the current level; the subtraction clamps at zero before
  // the floor is applied so large levels cannot wrap around.
  always_comb begin
    dec         = 32'(level) * 32'(GRAVITY_STEP);
    next_period = MP;
    if (dec < GP && (GP - dec) > MP) next_period = GP - dec;
  end

  always_comb begin
    fifo_full  = (fifo_cnt == FULL_CNT);
    start      = (phase == PH_IDLE || phase == PH_OVER) && press_any;
    // game_over is ignored while new_game is still pulsing so a stale
    // level from the previous game cannot bounce us straight back to OVER.
    go_over    = (phase == PH_RUN) && game_over && !new_game;
    active     = (phase == PH_RUN) && !go_over;
    can_issue  = active && (!cmd_valid || cmd_ready);
    issue_grav = can_issue && grav_pending;
    issue_btn  = can_issue && !grav_pending && (fifo_cnt != '0);
    push       = active && press_any && (!fifo_full || issue_btn);
    drop       = active && press_any && fifo_full && !issue_btn;
    tick       = active && (grav_cnt == cur_period - 32'd1);
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= press_code;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      btn_q        <= '0;
      phase        <= PH_IDLE;
      new_game     <= 1'b0;
      cmd_valid    <= 1'b0;
      cmd          <= '0;
      level        <= '0;
      overflow     <= 1'b0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fifo_cnt     <= '0;
      grav_cnt     <= '0;
      cur_period   <= BASE_PERIOD;
      grav_pending <= 1'b0;
      line_cnt     <= '0;
    end else begin
      btn_q    <= btn;
      new_game <= start;
      if (start) begin
        phase        <= PH_RUN;
        level        <= '0;
        line_cnt     <= '0;
        grav_cnt     <= '0;
        cur_period   <= BASE_PERIOD;
        grav_pending <= 1'b0;
      end else if (go_over) begin
        // Counter and level are held; queue and pending tick are discarded.
        phase        <= PH_OVER;
        cmd_valid    <= 1'b0;
        wr_ptr       <= '0;
        rd_ptr       <= '0;
        fifo_cnt     <= '0;
        grav_pending <= 1'b0;
      end else if (active) begin
        // The period is latched at each wrap so a level change mid-count
        // takes effect from the next interval.
        if (tick) begin
          grav_cnt   <= '0;
          cur_period <= next_period;
        end else begin
          grav_cnt <= grav_cnt + 32'd1;
        end
        grav_pending <= (grav_pending && !issue_grav) || tick;

        if (push)      wr_ptr <= wr_ptr + 1'b1;
        if (issue_btn) rd_ptr <= rd_ptr + 1'b1;
        case ({push, issue_btn})
          2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
          2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
          default: fifo_cnt <= fifo_cnt;
        endcase
        if (drop) overflow <= 1'b1;

        if (issue_grav) begin
          cmd_valid <= 1'b1;
          cmd       <= 3'd4;
        end else if (issue_btn) begin
          cmd_valid <= 1'b1;
          cmd       <= {1'b0, fifo_mem[rd_ptr]};
        end else if (cmd_valid && cmd_ready) begin
          cmd_valid <= 1'b0;
        end

        if (line_clear) begin
          if (line_cnt == LPL - 32'd1) begin
            line_cnt <= '0;
            if (level != 4'd15) level <= level + 4'd1;
          end else begin
            line_cnt <= line_cnt + 32'd1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_tetris_cmd_scheduler.sv
// Directed bench for tetris_cmd_scheduler with small timing parameters.
// Time is tracked as t = number of rising edges since the current game
// was started; each step samples #1 after the edge.
module tb_tetris_cmd_scheduler;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] btn;
  logic       cmd_ready;
  logic       line_clear;
  logic       game_over;
  logic       cmd_valid;
  logic [2:0] cmd;
  logic       new_game;
  logic [3:0] level;
  logic       overflow;
  logic [1:0] phase;

  int n_checks = 0;
  int n_err    = 0;
  int t        = 0;

  tetris_cmd_scheduler #(
    .GRAVITY_PERIOD(20), .GRAVITY_STEP(2), .MIN_PERIOD(6),
    .LINES_PER_LEVEL(2), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .reset(reset), .btn(btn), .cmd_ready(cmd_ready),
    .line_clear(line_clear), .game_over(game_over), .cmd_valid(cmd_valid),
    .cmd(cmd), .new_game(new_game), .level(level), .overflow(overflow),
    .phase(phase)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0d)", tag, obs, exp, t);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      t++;
    end
  endtask

  task automatic goto(input int n);
    while (t < n) step(1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"},    32'(cmd_valid), 0);
    check({tag, "_cmd"},      32'(cmd),       0);
    check({tag, "_new_game"}, 32'(new_game),  0);
    check({tag, "_level"},    32'(level),     0);
    check({tag, "_overflow"}, 32'(overflow),  0);
    check({tag, "_phase"},    32'(phase),     0);
  endtask

  // Reset, check reset values, press btn[0] to enter RUN; returns at t=2.
  task automatic start_game();
    reset = 1'b1; btn = '0; cmd_ready = 1'b0; line_clear = 1'b0; game_over = 1'b0;
    step(2);
    reset = 1'b0;
    step(1);
    check_reset_outputs("rst");
    btn = 4'b0001;
    t = 0;
    step(1);
    check("start_new_game", 32'(new_game),  1);
    check("start_phase",    32'(phase),     1);
    check("start_no_valid", 32'(cmd_valid), 0);
    btn = '0;
    step(1);
    check("start_new_game_drop", 32'(new_game), 0);
  endtask

  task automatic pulse_line();
    line_clear = 1'b1;
    step(1);
    line_clear = 1'b0;
    step(1);
  endtask

  // Steps until cmd_valid is seen (bounded); n = cycles waited.
  task automatic wait_valid(output int n);
    n = 0;
    do begin
      step(1);
      n++;
    end while (!cmd_valid && n < 200);
    check("wait_valid", 32'(cmd_valid), 1);
  endtask

  logic [2:0] exp_q[$];
  int n;
  int exp_period [1:10] = '{18, 16, 14, 12, 10, 8, 6, 6, 6, 6};

  initial begin
    // Gravity with cmd_ready tied high: one cmd=4 every 20 cycles.
    start_game();
    cmd_ready = 1'b1;
    wait_valid(n);
    check("grav_first_latency", n, 20);
    check("grav_first_cmd", 32'(cmd), 4);
    wait_valid(n);
    check("grav_interval", n, 20);
    check("grav_cmd", 32'(cmd), 4);
    step(1);
    check("grav_one_cycle", 32'(cmd_valid), 0);

    // Single press while stalled: 2-cycle latency, held, one handshake.
    start_game();
    btn = 4'b0010;
    step(1);
    check("lat_not_yet", 32'(cmd_valid), 0);
    step(1);
    check("lat_valid", 32'(cmd_valid), 1);
    check("lat_cmd", 32'(cmd), 1);
    for (int i = 0; i < 10; i++) begin
      step(1);
      check("hold_valid", 32'(cmd_valid), 1);
      check("hold_cmd", 32'(cmd), 1);
    end
    cmd_ready = 1'b1;
    step(1);
    check("hs_drop", 32'(cmd_valid), 0);
    step(1);
    check("hs_only_one", 32'(cmd_valid), 0);

    // Queue fill, overflow, and drain order.
    start_game();
    btn = 4'b0001; step(1);
    btn = 4'b0010; step(1);
    btn = 4'b0100; step(1);
    btn = 4'b1000; step(1);
    btn = 4'b0001; step(1);
    check("q_full_no_ovf", 32'(overflow), 0);
    btn = 4'b0010; step(1);
    check("q_ovf", 32'(overflow), 1);
    check("q_first_issued", 32'(cmd), 0);
    btn = '0;
    exp_q = '{3'd1, 3'd2, 3'd3, 3'd0};
    cmd_ready = 1'b1;
    while (exp_q.size() > 0) begin
      step(1);
      check("q_drain_valid", 32'(cmd_valid), 1);
      check("q_drain_cmd", 32'(cmd), 32'(exp_q.pop_front()));
    end
    step(1);
    check("q_drained", 32'(cmd_valid), 0);
    check("q_ovf_sticky", 32'(overflow), 1);

    // Gravity ahead of queued moves; a second tick during the stall merges.
    cmd_ready = 1'b0;
    btn = 4'b0010; step(1);
    btn = 4'b0000; step(1);
    btn = 4'b0100; step(1);
    btn = 4'b0000;
    goto(30);
    check("stall_valid", 32'(cmd_valid), 1);
    check("stall_cmd", 32'(cmd), 1);
    goto(42);
    cmd_ready = 1'b1;
    step(1);
    check("prio_grav_cmd", 32'(cmd), 4);
    check("prio_grav_valid", 32'(cmd_valid), 1);
    step(1);
    check("prio_btn_cmd", 32'(cmd), 2);
    step(1);
    check("merge_no_second", 32'(cmd_valid), 0);
    goto(50);
    check("merge_quiet", 32'(cmd_valid), 0);

    // Levels and gravity periods.
    start_game();
    cmd_ready = 1'b1;
    for (int l = 1; l <= 10; l++) begin
      pulse_line();
      pulse_line();
      check("lvl_value", 32'(level), 32'(l));
      wait_valid(n);
      wait_valid(n);
      check("lvl_period", n, 32'(exp_period[l]));
      check("lvl_cmd", 32'(cmd), 4);
    end
    for (int l = 11; l <= 15; l++) begin
      pulse_line();
      pulse_line();
      check("lvl_high", 32'(level), 32'(l));
    end
    pulse_line();
    pulse_line();
    check("lvl_saturate", 32'(level), 15);

    // game_over with a pending command, then restart; reset during stall.
    start_game();
    pulse_line();
    pulse_line();
    check("go_level_pre", 32'(level), 1);
    btn = 4'b1000; step(1);
    step(1);
    check("go_valid_pre", 32'(cmd_valid), 1);
    check("go_cmd_pre", 32'(cmd), 3);
    btn = 4'b0001; step(1);
    btn = 4'b0010; step(1);
    game_over = 1'b1;
    btn = '0;
    step(1);
    check("go_valid_off", 32'(cmd_valid), 0);
    check("go_phase", 32'(phase), 2);
    check("go_level_held", 32'(level), 1);
    step(1);
    check("go_valid_still_off", 32'(cmd_valid), 0);
    btn = 4'b0100;
    step(1);
    check("go_new_game", 32'(new_game), 1);
    check("go_restart_phase", 32'(phase), 1);
    check("go_restart_level", 32'(level), 0);
    step(1);
    check("go_ignored_phase", 32'(phase), 1);
    check("go_new_game_once", 32'(new_game), 0);
    game_over = 1'b0;
    cmd_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step(1);
      check("go_fifo_flushed", 32'(cmd_valid), 0);
    end
    cmd_ready = 1'b0;
    btn = 4'b0010;
    step(2);
    check("rst_stall_valid", 32'(cmd_valid), 1);
    check("rst_stall_cmd", 32'(cmd), 1);
    reset = 1'b1;
    step(1);
    check_reset_outputs("mid_rst");
    reset = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
